// File: rtl/north_sensor_if.sv
// Sensor bus between the intersection controller and the north approach
// sensor: road selection and vehicle-count reading in, running average out.
interface north_sensor_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       next_road;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] avg;

    modport master (
        output next_road,
        output data_in,
        input  avg
    );

    modport slave (
        input  next_road,
        input  data_in,
        output avg
    );
endinterface

// File: rtl/north_sensor.sv
// North-approach traffic sensor front end. Takes one vehicle-count sample on
// each entry into north selection and keeps the floor average of the last
// DEPTH samples. Empty slots count as zero, so the average ramps up after reset.
module north_sensor #(
    parameter int         WIDTH   = 8,
    parameter int         DEPTH   = 4,
    parameter logic [1:0] ROAD_ID = 2'b00
) (
    input  logic            clk,
    input  logic            reset,
    north_sensor_if.slave   bus
);
    localparam int LOG2D = $clog2(DEPTH);
    localparam int SUMW  = WIDTH + LOG2D;

    logic [WIDTH-1:0] r_slot [DEPTH];
    logic [SUMW-1:0]  r_sum;
    logic [LOG2D-1:0] r_wptr;
    logic [1:0]       r_prev_road;
    logic [WIDTH-1:0] r_avg;

    logic             w_event;
    logic [WIDTH-1:0] w_old;
    logic [SUMW-1:0]  w_sum_next;

    // Sample only on the transition into north selection, not while it is held.
    assign w_event    = (bus.next_road == ROAD_ID) && (r_prev_road != ROAD_ID);
    assign w_old      = r_slot[r_wptr];
    // Sum is wide enough for DEPTH full-scale samples, so this never wraps.
    assign w_sum_next = r_sum - SUMW'(w_old) + SUMW'(bus.data_in);

    // Previous-road tracker; reset value is chosen to differ from ROAD_ID so a
    // north selection present at reset release counts as an entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_road <= ~ROAD_ID;
        end else begin
            r_prev_road <= bus.next_road;
        end
    end

    // Sample history ring, running sum and write pointer, updated per event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i] <= '0;
            end
            r_sum  <= '0;
            r_wptr <= '0;
        end else if (w_event) begin
            r_slot[r_wptr] <= bus.data_in;
            r_sum          <= w_sum_next;
            r_wptr         <= r_wptr + LOG2D'(1);
        end
    end

    // Registered floor average; trails the sum update by one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_avg <= '0;
        end else begin
            r_avg <= WIDTH'(r_sum >> LOG2D);
        end
    end

    assign bus.avg = r_avg;

endmodule

// File: tb/tb_north_sensor.sv
// Self-checking bench for north_sensor: table-driven sample sequences, hand
// corner cases, and random traffic against a queue-based averaging model.
module tb_north_sensor;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    north_sensor_if #(.WIDTH(8)) bus ();

    north_sensor #(
        .WIDTH  (8),
        .DEPTH  (DEPTH),
        .ROAD_ID(2'b00)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: last DEPTH samples in a queue, previous road as int.
    int hist[$];
    int m_prev;
    int m_exp;

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_avg;
    } vec_t;

    vec_t seq_tbl[6];
    vec_t max_tbl[4];

    function automatic int model_sum();
        int s = 0;
        foreach (hist[i]) s += hist[i];
        return s;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: avg=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic [1:0] road, input logic [7:0] d);
        bus.next_road = road;
        bus.data_in   = d;
        @(posedge clk);
        if (!rst) begin
            m_exp = model_sum() / DEPTH;
            if (road == 2'd0 && m_prev != 0) begin
                hist.push_back(int'(d));
                if (hist.size() > DEPTH) void'(hist.pop_front());
            end
            m_prev = int'(road);
        end
        #1;
        check("model", bus.avg, 8'(m_exp));
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        hist.delete();
        m_prev = -1;
        m_exp  = 0;
        #1;
        check("async_reset", bus.avg, 8'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic north_entry(input logic [7:0] d);
        for (int i = 0; i < 5; i++) tick(2'd3, 8'd0);
        for (int i = 0; i < 5; i++) tick(2'd0, d);
    endtask

    initial begin
        seq_tbl[0] = '{8'd12, 8'd3};
        seq_tbl[1] = '{8'd20, 8'd8};
        seq_tbl[2] = '{8'd30, 8'd15};
        seq_tbl[3] = '{8'd10, 8'd18};
        seq_tbl[4] = '{8'd10, 8'd17};
        seq_tbl[5] = '{8'd20, 8'd17};
        max_tbl[0] = '{8'd255, 8'd63};
        max_tbl[1] = '{8'd255, 8'd127};
        max_tbl[2] = '{8'd255, 8'd191};
        max_tbl[3] = '{8'd255, 8'd255};

        rst           = 1'b1;
        bus.next_road = 2'd3;
        bus.data_in   = 8'd0;
        hist.delete();
        m_prev = -1;
        m_exp  = 0;
        #1;
        check("reset_avg", bus.avg, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Alternating 3/0 every 5 clocks, including ring wrap-around.
        foreach (seq_tbl[i]) begin
            north_entry(seq_tbl[i].data);
            check($sformatf("seq_%0d", i), bus.avg, seq_tbl[i].exp_avg);
        end

        // Held north selection: only the first edge's value is sampled.
        pulse_reset();
        tick(2'd3, 8'd0);
        tick(2'd3, 8'd0);
        for (int i = 0; i < 20; i++) tick(2'd0, 8'(40 + 3 * i));
        check("hold_first_only", bus.avg, 8'd10);

        // Switching between non-north roads never samples.
        pulse_reset();
        for (int i = 0; i < 30; i++) tick((i % 2 == 0) ? 2'd3 : 2'd1, 8'd200);
        check("non_north_toggle", bus.avg, 8'd0);

        // Reset mid-operation discards history, then restart.
        north_entry(8'd100);
        north_entry(8'd60);
        check("pre_reset_avg", bus.avg, 8'd40);
        pulse_reset();
        north_entry(8'd40);
        check("after_reset_1", bus.avg, 8'd10);
        north_entry(8'd40);
        check("after_reset_2", bus.avg, 8'd20);

        // North already selected when reset releases: event at first edge.
        #2;
        rst           = 1'b1;
        bus.next_road = 2'd0;
        bus.data_in   = 8'd100;
        hist.delete();
        m_prev = -1;
        m_exp  = 0;
        @(negedge clk);
        rst = 1'b0;
        tick(2'd0, 8'd100);
        tick(2'd0, 8'd7);
        check("first_edge_event", bus.avg, 8'd25);

        // Full-scale input, no overflow.
        pulse_reset();
        foreach (max_tbl[i]) begin
            north_entry(max_tbl[i].data);
            check($sformatf("max_%0d", i), bus.avg, max_tbl[i].exp_avg);
        end

        // Random traffic against the model, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic [1:0] r;
            r = ($urandom_range(0, 2) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            tick(r, 8'($urandom));
            if ($urandom_range(0, 199) == 0) pulse_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
